sram_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the single-port synchronous `SRAM` block (1024 x 8).
- Each cycle it grants at most one read/write request using round-robin priority and drives the registered command onto the SRAM port.
- It routes read data (or a write acknowledge) back to the issuing requester through a tagged response pipeline.
- It sits between two bus masters (e.g. a DMA engine and a CPU-side port) and the `SRAM` instance.

---
 rtl/sram_arbiter.sv | 161 ++++++++++++++++
 tb/tb_sram_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// sram_arbiter
//
// Two-requester round-robin arbiter and command sequencer for a single-port
// synchronous SRAM. At most one request is accepted per cycle. The accepted
// command is registered onto the SRAM port. A tagged shift register carries
// {valid, requester id, is_read} alongside the SRAM access. That tag steers the
// read data, or a zero-data write acknowledge, back to the issuing requester.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   reqN_valid/ready      request handshake, N = 0,1 (ready is combinational)
//   reqN_we/addr/wdata    request command (1 = write)
//   rspN_valid/rdata      one-cycle response pulse, read data (0 for writes)
//   sram_addr/we/din      registered command to the SRAM
//   sram_dout             SRAM read data, valid RD_LAT cycles after sampling
// -----------------------------------------------------------------------------
module sram_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1   // legal range 1..4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_we,
  output logic [DATA_W-1:0] sram_din,
  input  logic [DATA_W-1:0] sram_dout
);

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic              last_grant_reg;
  logic              grant0;
  logic              grant1;
  logic              accept;
  logic              accept_id;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  // A lone requester always wins. On contention, the requester that did not
  // win the previous accepted transfer goes first.
  always_comb begin
    grant0 = req0_valid && (!req1_valid || last_grant_reg);
    grant1 = req1_valid && (!req0_valid || !last_grant_reg);
  end

  // Gating with rst_n keeps both readies low while reset is held, even though
  // they are combinational.
  assign req0_ready = grant0 && rst_n;
  assign req1_ready = grant1 && rst_n;

  assign accept    = req0_ready || req1_ready;
  assign accept_id = req1_ready;
  assign cmd_we    = accept_id ? req1_we    : req0_we;
  assign cmd_addr  = accept_id ? req1_addr  : req0_addr;
  assign cmd_wdata = accept_id ? req1_wdata : req0_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_reg <= 1'b1;   // requester 0 wins the first contention
    end else if (accept) begin
      last_grant_reg <= accept_id;
    end
  end

  // ---------------------------------------------------------------------------
  // Command stage
  // Address and data hold between commands. Only the write strobe is cleared,
  // so each accepted write produces exactly one sram_we cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sram_addr <= '0;
      sram_din  <= '0;
      sram_we   <= 1'b0;
    end else begin
      sram_we <= accept && cmd_we;
      if (accept) begin
        sram_addr <= cmd_addr;
        sram_din  <= cmd_wdata;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Response tag pipeline
  // Stage 0 is loaded together with the command register, so stage k is
  // visible in the same cycle as the command plus k. Stage RD_LAT therefore
  // lines up with the cycle in which sram_dout carries that command's data.
  // ---------------------------------------------------------------------------
  logic [RD_LAT:0] pipe_valid_reg;
  logic [RD_LAT:0] pipe_id_reg;
  logic [RD_LAT:0] pipe_rd_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_valid_reg <= '0;
      pipe_id_reg    <= '0;
      pipe_rd_reg    <= '0;
    end else begin
      pipe_valid_reg <= {pipe_valid_reg[RD_LAT-1:0], accept};
      pipe_id_reg    <= {pipe_id_reg[RD_LAT-1:0], accept_id};
      pipe_rd_reg    <= {pipe_rd_reg[RD_LAT-1:0], !cmd_we};
    end
  end

  // ---------------------------------------------------------------------------
  // Per-requester response registers
  // Read data holds between responses. A write acknowledge overwrites it
  // with zero.
  // ---------------------------------------------------------------------------
  logic [1:0]        rsp_valid_vec;
  logic [DATA_W-1:0] rsp_rdata_vec [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
    logic              hit;
    logic              rsp_valid_reg;
    logic [DATA_W-1:0] rsp_rdata_reg;

    assign hit = pipe_valid_reg[RD_LAT] && (pipe_id_reg[RD_LAT] == 1'(gi));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rsp_valid_reg <= 1'b0;
        rsp_rdata_reg <= '0;
      end else begin
        rsp_valid_reg <= hit;
        if (hit) begin
          rsp_rdata_reg <= pipe_rd_reg[RD_LAT] ? sram_dout : '0;
        end
      end
    end

    assign rsp_valid_vec[gi] = rsp_valid_reg;
    assign rsp_rdata_vec[gi] = rsp_rdata_reg;
  end

  assign rsp0_valid = rsp_valid_vec[0];
  assign rsp1_valid = rsp_valid_vec[1];
  assign rsp0_rdata = rsp_rdata_vec[0];
  assign rsp1_rdata = rsp_rdata_vec[1];

endmodule

// File: tb/tb_sram_arbiter.sv
`timescale 1ns/1ps
// Testbench for sram_arbiter. Two instances run side by side from identical
// stimulus: one with RD_LAT = 1 and one with RD_LAT = 3. Each instance has its
// own behavioural SRAM. A transaction-level reference model predicts arbitration,
// SRAM commands and response timing/data. That model holds a flat memory image
// and per-requester queues of (due cycle, data).
module tb_sram_arbiter;

  localparam int AW = 10;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          v0, we0, v1, we1;
  logic [AW-1:0] a0, a1;
  logic [DW-1:0] d0, d1;

  logic [1:0]    r0, r1, rv0, rv1, swe;
  logic [DW-1:0] rd0 [2];
  logic [DW-1:0] rd1 [2];
  logic [DW-1:0] sdin [2];
  logic [DW-1:0] sdout [2];
  logic [AW-1:0] saddr [2];

  function automatic logic [DW-1:0] preload(input int i);
    return (i < 8) ? DW'(8'h10 + i) : DW'(i * 37 + 3);
  endfunction

  function automatic int lat_of(input int inst);
    return (inst == 0) ? 1 : 3;
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam int LAT = (gi == 0) ? 1 : 3;
    logic [DW-1:0] mem  [1024];
    logic [DW-1:0] pipe [LAT];
    bit            loaded = 1'b0;

    sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(v0), .req0_ready(r0[gi]), .req0_we(we0), .req0_addr(a0),
      .req0_wdata(d0), .rsp0_valid(rv0[gi]), .rsp0_rdata(rd0[gi]),
      .req1_valid(v1), .req1_ready(r1[gi]), .req1_we(we1), .req1_addr(a1),
      .req1_wdata(d1), .rsp1_valid(rv1[gi]), .rsp1_rdata(rd1[gi]),
      .sram_addr(saddr[gi]), .sram_we(swe[gi]), .sram_din(sdin[gi]),
      .sram_dout(sdout[gi])
    );

    // Behavioural synchronous SRAM: samples the command on the rising edge,
    // and read data emerges LAT cycles later.
    always @(posedge clk) begin
      if (!loaded) begin
        for (int i = 0; i < 1024; i++) mem[i] <= preload(i);
        loaded <= 1'b1;
      end else if (swe[gi]) begin
        mem[saddr[gi]] <= sdin[gi];
      end
      pipe[0] <= mem[saddr[gi]];
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign sdout[gi] = pipe[LAT-1];
  end

  // ---------------------------------------------------------------------------
  // Reference model state
  // ---------------------------------------------------------------------------
  typedef struct { int due; logic [DW-1:0] data; } rsp_t;
  rsp_t          exp_q [4][$];      // index = instance*2 + requester
  logic [DW-1:0] last_rdata [4];
  logic [DW-1:0] ref_mem [1024];
  bit            lg;
  bit            exp_we;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_din;
  int            cyc = 0;
  int            last_winner;
  int            checks = 0;
  int            errors = 0;

  task automatic check(input string name, input int inst, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (lat%0d) cycle %0d: got %0h expected %0h",
               name, lat_of(inst), cyc, act, exp);
    end
  endtask

  // Compare one cycle against the model, then advance the model and the clock.
  task automatic tick(input bit use_tab, input bit tr0, input bit tr1);
    int            winner;
    int            k;
    bit            act_v;
    logic [DW-1:0] act_d;
    bit            rq_we;
    logic [AW-1:0] rq_a;
    logic [DW-1:0] rq_d;
    logic [DW-1:0] rsp_d;
    @(negedge clk);
    if (!rst_n) begin
      for (int j = 0; j < 4; j++) begin
        exp_q[j].delete();
        last_rdata[j] = '0;
      end
      exp_we = 1'b0; exp_addr = '0; exp_din = '0; lg = 1'b1;
    end
    winner = -1;
    if (rst_n) begin
      if (v0 && v1)  winner = lg ? 0 : 1;   // whoever did not win last time
      else if (v0)   winner = 0;
      else if (v1)   winner = 1;
    end
    for (int i = 0; i < 2; i++) begin
      check("req0_ready", i, 32'(r0[i]), 32'(winner == 0));
      check("req1_ready", i, 32'(r1[i]), 32'(winner == 1));
      if (use_tab) begin
        check("tab_ready0", i, 32'(r0[i]), 32'(tr0));
        check("tab_ready1", i, 32'(r1[i]), 32'(tr1));
      end
      check("sram_we",   i, 32'(swe[i]),   32'(exp_we));
      check("sram_addr", i, 32'(saddr[i]), 32'(exp_addr));
      check("sram_din",  i, 32'(sdin[i]),  32'(exp_din));
      for (int r = 0; r < 2; r++) begin
        k     = i * 2 + r;
        act_v = (r == 0) ? rv0[i] : rv1[i];
        act_d = (r == 0) ? rd0[i] : rd1[i];
        if (exp_q[k].size() > 0 && exp_q[k][0].due == cyc) begin
          check(r == 0 ? "rsp0_valid" : "rsp1_valid", i, 32'(act_v), 32'd1);
          check(r == 0 ? "rsp0_rdata" : "rsp1_rdata", i, 32'(act_d), 32'(exp_q[k][0].data));
          last_rdata[k] = exp_q[k][0].data;
          void'(exp_q[k].pop_front());
        end else begin
          check(r == 0 ? "rsp0_valid" : "rsp1_valid", i, 32'(act_v), 32'd0);
          check(r == 0 ? "rsp0_rdata_hold" : "rsp1_rdata_hold", i, 32'(act_d),
                32'(last_rdata[k]));
        end
      end
    end
    if (winner >= 0) begin
      rq_we = (winner == 0) ? we0 : we1;
      rq_a  = (winner == 0) ? a0  : a1;
      rq_d  = (winner == 0) ? d0  : d1;
      if (rq_we) begin
        ref_mem[rq_a] = rq_d;
        rsp_d = '0;
      end else begin
        rsp_d = ref_mem[rq_a];
      end
      for (int i = 0; i < 2; i++) exp_q[i*2+winner].push_back('{cyc + 2 + lat_of(i), rsp_d});
      exp_we = rq_we; exp_addr = rq_a; exp_din = rq_d; lg = (winner == 1);
      $display("cycle %0d: req%0d %s addr=%03h data=%02h", cyc, winner,
               rq_we ? "write" : "read ", rq_a, rq_we ? rq_d : rsp_d);
    end else begin
      exp_we = 1'b0;
    end
    last_winner = winner;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Directed vectors
  // ---------------------------------------------------------------------------
  typedef struct {
    bit v0; bit we0; logic [AW-1:0] a0; logic [DW-1:0] d0;
    bit v1; bit we1; logic [AW-1:0] a1; logic [DW-1:0] d1;
    bit er0; bit er1;
  } vec_t;
  vec_t tab [$];

  function automatic vec_t mk(input bit pv0, input bit pwe0, input int pa0, input int pd0,
                              input bit pv1, input bit pwe1, input int pa1, input int pd1,
                              input bit e0, input bit e1);
    vec_t t;
    t.v0 = pv0; t.we0 = pwe0; t.a0 = AW'(pa0); t.d0 = DW'(pd0);
    t.v1 = pv1; t.we1 = pwe1; t.a1 = AW'(pa1); t.d1 = DW'(pd1);
    t.er0 = e0; t.er1 = e1;
    return t;
  endfunction

  task automatic idle(input int n);
    v0 = 1'b0; v1 = 1'b0;
    for (int i = 0; i < n; i++) tick(1'b1, 1'b0, 1'b0);
  endtask

  bit p0, p1;

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = preload(i);
    // Hold valids high during power-on reset: readies must stay low.
    v0 = 1'b1; we0 = 1'b0; a0 = '0; d0 = '0;
    v1 = 1'b1; we1 = 1'b0; a1 = '0; d1 = '0;
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    rst_n = 1'b1;
    idle(2);

    // Streaming reads from requester 1, then write/read, contention, hazard.
    for (int i = 0; i < 8; i++) tab.push_back(mk(0, 0, 0, 0, 1, 0, i, 0, 0, 1));
    for (int i = 0; i < 6; i++) tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tab.push_back(mk(1, 1, 5, 8'hAA, 0, 0, 0, 0, 1, 0));
    tab.push_back(mk(1, 0, 5, 0,     0, 0, 0, 0, 1, 0));
    for (int i = 0; i < 4; i++) tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tab.push_back(mk(0, 0, 0, 0,          1, 1, 'h20, 'h33, 0, 1));
    tab.push_back(mk(1, 0, 'h20, 0,       1, 1, 'h21, 'h44, 1, 0));
    tab.push_back(mk(1, 1, 'h22, 'h55,    1, 1, 'h21, 'h44, 0, 1));
    tab.push_back(mk(1, 1, 'h22, 'h55,    1, 0, 'h21, 0,    1, 0));
    tab.push_back(mk(1, 0, 'h22, 0,       1, 0, 'h21, 0,    0, 1));
    tab.push_back(mk(1, 0, 'h22, 0,       1, 0, 'h20, 0,    1, 0));
    tab.push_back(mk(1, 0, 5, 0,          1, 0, 'h20, 0,    0, 1));
    tab.push_back(mk(1, 0, 5, 0,          0, 0, 0, 0,       1, 0));
    for (int i = 0; i < 6; i++) tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tab.push_back(mk(0, 0, 0, 0,     1, 1, 'h3FF, 'h5C, 0, 1));
    tab.push_back(mk(1, 0, 'h3FF, 0, 0, 0, 0, 0,        1, 0));
    for (int i = 0; i < 6; i++) tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    foreach (tab[n]) begin
      v0 = tab[n].v0; we0 = tab[n].we0; a0 = tab[n].a0; d0 = tab[n].d0;
      v1 = tab[n].v1; we1 = tab[n].we1; a1 = tab[n].a1; d1 = tab[n].d1;
      tick(1'b1, tab[n].er0, tab[n].er1);
    end

    // Reset in the middle of a read stream: in-flight responses are dropped
    // and the first contention afterwards goes to requester 0.
    v0 = 1'b1; we0 = 1'b0; a0 = AW'('h30);
    v1 = 1'b1; we1 = 1'b0; a1 = AW'('h31);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick(1'b1, 1'b1, 1'b0);
    v0 = 1'b0;
    tick(1'b1, 1'b0, 1'b1);
    idle(7);

    // Randomised traffic on a small address window to provoke hazards.
    p0 = 1'b0; p1 = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (!p0 && $urandom_range(0, 3) != 0) begin
        p0 = 1'b1; we0 = 1'($urandom_range(0, 1));
        a0 = AW'($urandom_range(0, 15)); d0 = DW'($urandom);
      end
      if (!p1 && $urandom_range(0, 3) != 0) begin
        p1 = 1'b1; we1 = 1'($urandom_range(0, 1));
        a1 = AW'($urandom_range(0, 15)); d1 = DW'($urandom);
      end
      v0 = p0; v1 = p1;
      tick(1'b0, 1'b0, 1'b0);
      if (last_winner == 0) p0 = 1'b0;
      if (last_winner == 1) p1 = 1'b0;
    end
    idle(8);

    for (int k = 0; k < 4; k++) begin
      check("drained", k / 2, 32'(exp_q[k].size()), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
